// File: rtl/axi_ddr3_memtest.sv
// Purpose: AXI4 master that writes an LFSR pattern over a region in 4x32-bit bursts, reads it back and counts errors.
// Latency: AW valid the cycle after start; then one handshake per beat, one outstanding transaction at a time.
// Backpressure: every channel waits indefinitely on ready/valid; valid, address and data hold while stalled.
//
// Ports: clock/reset_ni (synchronous, active-low); start_i/base_i launch a test;
// busy_o/done_o/pass_o/errors_o report status; axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r* form the AXI4 master.
// Optional macro MEMTEST_ERROR_CAPTURE_EN adds fail_addr_o/fail_exp_o/fail_got_o (first data-mismatch beat).
module axi_ddr3_memtest #(
    parameter int          WIDTH  = 32,
    parameter int          ADDRS  = 27,
    parameter int          REQID  = 4,
    parameter int          BURSTS = 16,
    parameter logic [31:0] SEED   = 32'h1234_5678
) (
    input  logic                 clock,
    input  logic                 reset_ni,
    input  logic                 start_i,
    input  logic [ADDRS-1:0]     base_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [15:0]          errors_o,
    output logic                 axi_awvalid_o,
    input  logic                 axi_awready_i,
    output logic [ADDRS-1:0]     axi_awaddr_o,
    output logic [REQID-1:0]     axi_awid_o,
    output logic [7:0]           axi_awlen_o,
    output logic [1:0]           axi_awburst_o,
    output logic                 axi_wvalid_o,
    input  logic                 axi_wready_i,
    output logic                 axi_wlast_o,
    output logic [WIDTH/8-1:0]   axi_wstrb_o,
    output logic [WIDTH-1:0]     axi_wdata_o,
    input  logic                 axi_bvalid_i,
    output logic                 axi_bready_o,
    input  logic [1:0]           axi_bresp_i,
    input  logic [REQID-1:0]     axi_bid_i,
    output logic                 axi_arvalid_o,
    input  logic                 axi_arready_i,
    output logic [ADDRS-1:0]     axi_araddr_o,
    output logic [REQID-1:0]     axi_arid_o,
    output logic [7:0]           axi_arlen_o,
    output logic [1:0]           axi_arburst_o,
    input  logic                 axi_rvalid_i,
    output logic                 axi_rready_o,
    input  logic                 axi_rlast_i,
    input  logic [1:0]           axi_rresp_i,
    input  logic [REQID-1:0]     axi_rid_i,
    input  logic [WIDTH-1:0]     axi_rdata_i
`ifdef MEMTEST_ERROR_CAPTURE_EN
    ,
    output logic [ADDRS-1:0]     fail_addr_o,
    output logic [WIDTH-1:0]     fail_exp_o,
    output logic [WIDTH-1:0]     fail_got_o
`endif
);

    localparam int          CW   = $clog2(BURSTS) + 1;
    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [CW-1:0] LAST_BURST = CW'(BURSTS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDRS-1:0]  base_q;
    logic [ADDRS-1:0]  addr_q;
    logic [CW-1:0]     burst_q;
    logic [1:0]        beat_q;
    logic [31:0]       lfsr_q;
    logic [31:0]       lfsr_nxt;
    logic [15:0]       errors_q;
    logic [1:0]        err_inc;
    logic [16:0]       err_sum;
    logic [15:0]       errors_sat;
    logic              last_burst;
    logic              data_bad;
    logic              unused_inputs;

    // ID fields are always 0 so responses need no ID matching; base low nibble is forced to 0.
    assign unused_inputs = ^{base_i[3:0], axi_bid_i, axi_rid_i};

    assign last_burst = (burst_q == LAST_BURST);
    assign data_bad   = (axi_rdata_i != lfsr_q[WIDTH-1:0]);

    // Galois LFSR, shifting right; taps folded in when the outgoing bit is 1.
    always_comb begin
        lfsr_nxt = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_nxt = (lfsr_q >> 1) ^ TAPS;
        end
    end

    // Per-beat error contribution; a read beat can add up to 3 (data, resp, rlast placement).
    always_comb begin
        err_inc = 2'd0;
        if (state_q == S_B && axi_bvalid_i) begin
            err_inc = 2'(axi_bresp_i != 2'b00);
        end else if (state_q == S_R && axi_rvalid_i) begin
            err_inc = 2'(data_bad) + 2'(axi_rresp_i != 2'b00)
                    + 2'(axi_rlast_i != (beat_q == 2'd3));
        end
        err_sum    = {1'b0, errors_q} + 17'(err_inc);
        errors_sat = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        axi_awvalid_o = 1'b0;
        axi_wvalid_o  = 1'b0;
        axi_bready_o  = 1'b0;
        axi_arvalid_o = 1'b0;
        axi_rready_o  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) state_d = S_AW;
            end
            S_AW: begin
                axi_awvalid_o = 1'b1;
                if (axi_awready_i) state_d = S_W;
            end
            S_W: begin
                axi_wvalid_o = 1'b1;
                if (axi_wready_i && beat_q == 2'd3) state_d = S_B;
            end
            S_B: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) state_d = last_burst ? S_AR : S_AW;
            end
            S_AR: begin
                axi_arvalid_o = 1'b1;
                if (axi_arready_i) state_d = S_R;
            end
            S_R: begin
                axi_rready_o = 1'b1;
                if (axi_rvalid_i && beat_q == 2'd3) state_d = last_burst ? S_DONE : S_AR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            burst_q  <= '0;
            beat_q   <= 2'd0;
            lfsr_q   <= SEED;
            errors_q <= 16'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        base_q   <= {base_i[ADDRS-1:4], 4'b0000};
                        addr_q   <= {base_i[ADDRS-1:4], 4'b0000};
                        burst_q  <= '0;
                        beat_q   <= 2'd0;
                        lfsr_q   <= SEED;
                        errors_q <= 16'd0;
                    end
                end
                S_W: begin
                    if (axi_wready_i) begin
                        lfsr_q <= lfsr_nxt;
                        beat_q <= beat_q + 2'd1;
                    end
                end
                S_B: begin
                    if (axi_bvalid_i) begin
                        errors_q <= errors_sat;
                        if (last_burst) begin
                            // Rewind so the read phase regenerates the written sequence.
                            burst_q <= '0;
                            addr_q  <= base_q;
                            lfsr_q  <= SEED;
                        end else begin
                            burst_q <= burst_q + CW'(1);
                            addr_q  <= addr_q + ADDRS'(16);
                        end
                    end
                end
                S_R: begin
                    if (axi_rvalid_i) begin
                        errors_q <= errors_sat;
                        lfsr_q   <= lfsr_nxt;
                        beat_q   <= beat_q + 2'd1;
                        if (beat_q == 2'd3 && !last_burst) begin
                            burst_q <= burst_q + CW'(1);
                            addr_q  <= addr_q + ADDRS'(16);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEMTEST_ERROR_CAPTURE_EN
    logic cap_vld_q;

    always_ff @(posedge clock) begin
        if (!reset_ni) begin
            cap_vld_q   <= 1'b0;
            fail_addr_o <= '0;
            fail_exp_o  <= '0;
            fail_got_o  <= '0;
        end else if ((state_q == S_IDLE || state_q == S_DONE) && start_i) begin
            cap_vld_q   <= 1'b0;
            fail_addr_o <= '0;
            fail_exp_o  <= '0;
            fail_got_o  <= '0;
        end else if (state_q == S_R && axi_rvalid_i && data_bad && !cap_vld_q) begin
            cap_vld_q   <= 1'b1;
            fail_addr_o <= addr_q + ADDRS'({beat_q, 2'b00});
            fail_exp_o  <= lfsr_q[WIDTH-1:0];
            fail_got_o  <= axi_rdata_i;
        end
    end
`else
    // Error capture registers are not built in this configuration.
`endif

    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o        = (state_q == S_DONE);
    assign pass_o        = (state_q == S_DONE) && (errors_q == 16'd0);
    assign errors_o      = errors_q;

    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = '0;
    assign axi_awlen_o   = 8'd3;
    assign axi_awburst_o = 2'b01;
    assign axi_wlast_o   = (state_q == S_W) && (beat_q == 2'd3);
    assign axi_wstrb_o   = '1;
    assign axi_wdata_o   = lfsr_q[WIDTH-1:0];
    assign axi_araddr_o  = addr_q;
    assign axi_arid_o    = '0;
    assign axi_arlen_o   = 8'd3;
    assign axi_arburst_o = 2'b01;

endmodule

// File: tb/tb_axi_ddr3_memtest.sv
// Purpose: directed bench for axi_ddr3_memtest against a behavioural AXI slave memory.
// Latency: slave responds after 0..stall_max cycles per handshake.
// Backpressure: slave stalls every channel when stall_max > 0.
module tb_axi_ddr3_memtest;
    localparam int ADDRS = 27;
    localparam int WIDTH = 32;
    localparam int REQID = 4;

    logic              clock = 1'b0;
    logic              reset_ni;
    logic              start_i;
    logic [ADDRS-1:0]  base_i;
    logic              busy_o, done_o, pass_o;
    logic [15:0]       errors_o;
    logic              axi_awvalid_o, axi_awready_i;
    logic [ADDRS-1:0]  axi_awaddr_o;
    logic [REQID-1:0]  axi_awid_o;
    logic [7:0]        axi_awlen_o;
    logic [1:0]        axi_awburst_o;
    logic              axi_wvalid_o, axi_wready_i, axi_wlast_o;
    logic [3:0]        axi_wstrb_o;
    logic [WIDTH-1:0]  axi_wdata_o;
    logic              axi_bvalid_i, axi_bready_o;
    logic [1:0]        axi_bresp_i;
    logic [REQID-1:0]  axi_bid_i;
    logic              axi_arvalid_o, axi_arready_i;
    logic [ADDRS-1:0]  axi_araddr_o;
    logic [REQID-1:0]  axi_arid_o;
    logic [7:0]        axi_arlen_o;
    logic [1:0]        axi_arburst_o;
    logic              axi_rvalid_i, axi_rready_o, axi_rlast_i;
    logic [1:0]        axi_rresp_i;
    logic [REQID-1:0]  axi_rid_i;
    logic [WIDTH-1:0]  axi_rdata_i;
`ifdef MEMTEST_ERROR_CAPTURE_EN
    logic [ADDRS-1:0]  fail_addr_o;
    logic [WIDTH-1:0]  fail_exp_o, fail_got_o;
`endif

    axi_ddr3_memtest dut (
        .clock(clock), .reset_ni(reset_ni), .start_i(start_i), .base_i(base_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .errors_o(errors_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
        .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
        .axi_wlast_o(axi_wlast_o), .axi_wstrb_o(axi_wstrb_o), .axi_wdata_o(axi_wdata_o),
        .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
        .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
        .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
        .axi_rlast_i(axi_rlast_i), .axi_rresp_i(axi_rresp_i),
        .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i)
`ifdef MEMTEST_ERROR_CAPTURE_EN
        , .fail_addr_o(fail_addr_o), .fail_exp_o(fail_exp_o), .fail_got_o(fail_got_o)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave memory, logs and fault-injection controls.
    bit [31:0]        mem [bit [26:0]];
    logic [26:0]      aw_log[$];
    logic [26:0]      ar_log[$];
    logic [31:0]      w_log[$];
    logic [31:0]      ref_w[$];
    logic [31:0]      exp_w [0:63];
    int stall_max = 0;
    int corrupt_burst = -1, corrupt_beat = 0;
    int bad_b_burst = -1;
    int bad_r_burst = -1, bad_r_beat = 0;
    int stall_viol = 0, field_viol = 0;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    function automatic int dly();
        return (stall_max == 0) ? 0 : int'($urandom_range(0, stall_max));
    endfunction

    // Behavioural AXI slave: decides inputs on the falling edge; a handshake is
    // known at that point because neither side changes before the next rising edge.
    initial begin
        logic [26:0] cur_wa, cur_ra, p_awaddr, p_araddr;
        logic [31:0] p_wdata, d;
        logic        p_awv, p_awr, p_wv, p_wr, p_wl, p_arv, p_arr;
        int wbeat, rbeat, wr_burst, rd_burst;
        int aw_wait, w_wait, b_wait, ar_wait, r_wait;
        bit b_pend, r_pend;
        axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0; axi_bresp_i = 0;
        axi_bid_i = 0; axi_arready_i = 0; axi_rvalid_i = 0; axi_rlast_i = 0;
        axi_rresp_i = 0; axi_rid_i = 0; axi_rdata_i = 0;
        cur_wa = 0; cur_ra = 0; p_awaddr = 0; p_araddr = 0; p_wdata = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_wl = 0; p_arv = 0; p_arr = 0;
        wbeat = 0; rbeat = 0; wr_burst = 0; rd_burst = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        b_pend = 0; r_pend = 0;
        forever begin
            @(negedge clock);
            if (!reset_ni) begin
                axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0;
                axi_arready_i = 0; axi_rvalid_i = 0;
                wbeat = 0; rbeat = 0; wr_burst = 0; rd_burst = 0;
                b_pend = 0; r_pend = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (start_i && !busy_o) begin
                    wbeat = 0; rbeat = 0; wr_burst = 0; rd_burst = 0;
                end
                if (p_awv && !p_awr && (!axi_awvalid_o || axi_awaddr_o != p_awaddr)) stall_viol++;
                if (p_wv && !p_wr && (!axi_wvalid_o || axi_wdata_o != p_wdata || axi_wlast_o != p_wl)) stall_viol++;
                if (p_arv && !p_arr && (!axi_arvalid_o || axi_araddr_o != p_araddr)) stall_viol++;
                // B
                if (b_pend) begin
                    if (b_wait > 0) begin
                        axi_bvalid_i = 0; b_wait--;
                    end else begin
                        axi_bvalid_i = 1;
                        axi_bresp_i = (wr_burst == bad_b_burst) ? 2'b10 : 2'b00;
                        if (axi_bready_o) begin
                            b_pend = 0; wr_burst++; b_wait = dly();
                        end
                    end
                end else axi_bvalid_i = 0;
                // W
                if (axi_wvalid_o) begin
                    if (w_wait > 0) begin
                        axi_wready_i = 0; w_wait--;
                    end else begin
                        axi_wready_i = 1;
                        mem[cur_wa + 27'(4 * wbeat)] = axi_wdata_o;
                        w_log.push_back(axi_wdata_o);
                        if (axi_wlast_o != (wbeat == 3) || axi_wstrb_o != 4'hF) field_viol++;
                        wbeat++;
                        if (wbeat == 4) begin wbeat = 0; b_pend = 1; end
                        w_wait = dly();
                    end
                end else axi_wready_i = 0;
                // AW
                if (axi_awvalid_o) begin
                    if (aw_wait > 0) begin
                        axi_awready_i = 0; aw_wait--;
                    end else begin
                        axi_awready_i = 1;
                        cur_wa = axi_awaddr_o; wbeat = 0;
                        aw_log.push_back(axi_awaddr_o);
                        if (axi_awlen_o != 8'd3 || axi_awburst_o != 2'b01 || axi_awid_o != 0) field_viol++;
                        aw_wait = dly();
                    end
                end else axi_awready_i = 0;
                // R
                if (r_pend) begin
                    if (r_wait > 0) begin
                        axi_rvalid_i = 0; r_wait--;
                    end else begin
                        d = mem[cur_ra + 27'(4 * rbeat)];
                        if (rd_burst == corrupt_burst && rbeat == corrupt_beat) d = d ^ 32'd1;
                        axi_rvalid_i = 1;
                        axi_rdata_i = d;
                        axi_rlast_i = (rbeat == 3);
                        axi_rresp_i = (rd_burst == bad_r_burst && rbeat == bad_r_beat) ? 2'b10 : 2'b00;
                        if (axi_rready_o) begin
                            rbeat++;
                            if (rbeat == 4) begin rbeat = 0; r_pend = 0; rd_burst++; end
                            r_wait = dly();
                        end
                    end
                end else axi_rvalid_i = 0;
                // AR
                if (axi_arvalid_o) begin
                    if (ar_wait > 0) begin
                        axi_arready_i = 0; ar_wait--;
                    end else begin
                        axi_arready_i = 1;
                        cur_ra = axi_araddr_o; rbeat = 0; r_pend = 1;
                        ar_log.push_back(axi_araddr_o);
                        if (axi_arlen_o != 8'd3 || axi_arburst_o != 2'b01 || axi_arid_o != 0) field_viol++;
                        ar_wait = dly();
                    end
                end else axi_arready_i = 0;
            end
            p_awv = axi_awvalid_o; p_awr = axi_awready_i; p_awaddr = axi_awaddr_o;
            p_wv = axi_wvalid_o; p_wr = axi_wready_i; p_wdata = axi_wdata_o; p_wl = axi_wlast_o;
            p_arv = axi_arvalid_o; p_arr = axi_arready_i; p_araddr = axi_araddr_o;
        end
    end

    task automatic start_test(input logic [26:0] b);
        aw_log.delete(); w_log.delete(); ar_log.delete();
        base_i = b; start_i = 1;
        @(posedge clock); #1;
        start_i = 0;
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            @(posedge clock); #1; n++;
        end
        check("done_within_budget", done_o, 1);
    endtask

    // Address sequences must be base + 16*n modulo 2^27 on both AW and AR.
    task automatic check_addrs(input string tag, input logic [26:0] b);
        int bad = 0;
        logic [26:0] e;
        for (int i = 0; i < 16; i++) begin
            e = b + 27'(16 * i);
            if (i >= aw_log.size() || aw_log[i] !== e) bad++;
            if (i >= ar_log.size() || ar_log[i] !== e) bad++;
        end
        check({tag, "_aw_count"}, aw_log.size(), 16);
        check({tag, "_ar_count"}, ar_log.size(), 16);
        check({tag, "_addr_seq"}, bad, 0);
    endtask

    initial begin
        int bad;
        reset_ni = 0; start_i = 0; base_i = 0;
        exp_w[0] = 32'h1234_5678;
        for (int i = 1; i < 64; i++) exp_w[i] = lfsr_step(exp_w[i-1]);
        repeat (3) @(posedge clock);
        #1;
        // Reset state
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_pass", pass_o, 0);
        check("rst_errors", errors_o, 0);
        check("rst_valids", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 0);
        check("rst_readys", {axi_bready_o, axi_rready_o}, 0);
        check("rst_addr", {axi_awaddr_o, axi_araddr_o}, 0);
        reset_ni = 1;
        @(posedge clock); #1;

        // Zero-wait run from base 0
        start_test(27'h0);
        wait_done(3000);
        check("run1_pass", pass_o, 1);
        check("run1_errors", errors_o, 0);
        check("run1_busy", busy_o, 0);
        check_addrs("run1", 27'h0);
        check("run1_aw_last", aw_log[15], 27'h0F0);
        check("run1_w_count", w_log.size(), 64);
        check("run1_wdata0", w_log[0], 32'h1234_5678);
        check("run1_wdata1", w_log[1], 32'h091A_2B3C);
        check("run1_wdata2", w_log[2], 32'h048D_159E);
        check("run1_wdata3", w_log[3], 32'h0246_8ACF);
        check("run1_wdata4", w_log[4], 32'h8103_4564);
        bad = 0;
        for (int i = 0; i < 64; i++) if (i >= w_log.size() || w_log[i] !== exp_w[i]) bad++;
        check("run1_wdata_seq", bad, 0);
        check("run1_fields", field_viol, 0);
        ref_w = w_log;
        repeat (5) @(posedge clock);
        #1;
        check("done_held", done_o, 1);

        // Bit-0 corruption on read beat 2 of burst 5
        corrupt_burst = 5; corrupt_beat = 2;
        start_test(27'h0);
        wait_done(3000);
        check("corrupt_errors", errors_o, 1);
        check("corrupt_pass", pass_o, 0);
`ifdef MEMTEST_ERROR_CAPTURE_EN
        check("cap_addr", fail_addr_o, 27'h058);
        check("cap_exp", fail_exp_o, exp_w[22]);
        check("cap_got", fail_got_o, exp_w[22] ^ 32'd1);
`endif
        corrupt_burst = -1;

        // Random stalls on every channel
        stall_max = 7;
        stall_viol = 0;
        start_test(27'h0);
        wait_done(20000);
        check("stall_pass", pass_o, 1);
        check_addrs("stall", 27'h0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (i >= w_log.size() || w_log[i] !== ref_w[i]) bad++;
        check("stall_wdata_seq", bad, 0);
        check("stall_stable", stall_viol, 0);
        stall_max = 0;

        // Bad write response on burst 3 plus one bad read response
        bad_b_burst = 3; bad_r_burst = 7; bad_r_beat = 1;
        start_test(27'h0);
        wait_done(3000);
        check("badresp_errors", errors_o, 2);
        check("badresp_pass", pass_o, 0);
        bad_b_burst = -1; bad_r_burst = -1;

        // Reset in the middle of the write phase
        start_test(27'h0);
        bad = 0;
        while (!(axi_wvalid_o && w_log.size() >= 6) && bad < 500) begin
            @(posedge clock); #1; bad++;
        end
        check("midw_reached", axi_wvalid_o, 1);
        reset_ni = 0;
        @(posedge clock); #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_errors", errors_o, 0);
        check("midrst_valids", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, axi_bready_o, axi_rready_o}, 0);
        check("midrst_addr", axi_awaddr_o, 0);
        reset_ni = 1;
        @(posedge clock); #1;
        start_test(27'h100);
        wait_done(3000);
        check("restart_pass", pass_o, 1);
        check_addrs("restart", 27'h100);

        // Start pulse while busy is ignored
        start_test(27'h0);
        bad = 0;
        while (aw_log.size() < 3 && bad < 500) begin
            @(posedge clock); #1; bad++;
        end
        base_i = 27'h500; start_i = 1;
        @(posedge clock); #1;
        start_i = 0;
        check("busy_start_still_busy", busy_o, 1);
        wait_done(3000);
        check("busy_start_pass", pass_o, 1);
        check_addrs("busy_start", 27'h0);

        // Region crossing the top of the address space
        start_test(27'h7FF_FFE0);
        wait_done(3000);
        check("wrap_pass", pass_o, 1);
        check("wrap_aw0", aw_log[0], 27'h7FF_FFE0);
        check("wrap_aw1", aw_log[1], 27'h7FF_FFF0);
        check("wrap_aw2", aw_log[2], 27'h000);
        check("wrap_aw3", aw_log[3], 27'h010);
        check_addrs("wrap", 27'h7FF_FFE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
